cc_unit: RTL and testbench

//  Parametrised condition-code unit for the SLC-3 datapath.
//  - Derives N/Z/P from the value being written to DR (the bus value) and holds it in a 3-bit CC register.
//  - Provides an internal LIFO of saved CC values for interrupt entry/return.
//  - Registers the branch-enable (BEN) result for the control FSM.

---
 rtl/cc_unit.sv | 137 +++++++++++++
 tb/tb_cc_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cc_unit.sv
// Condition-code unit: NZP decode of the DR write value, a 3-bit CC register,
// a small LIFO of saved CC values for interrupt entry/return, and a registered BEN.
module cc_unit #(
    parameter int          DATA_W      = 16,
    parameter int          STACK_DEPTH = 4,
    parameter logic [2:0]  CC_RST      = 3'b010
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DATA_W-1:0]                  dr_value,
    input  logic                               ld_cc,
    input  logic                               cc_push,
    input  logic                               cc_pop,
    input  logic [2:0]                         ir_nzp,
    input  logic                               ld_ben,
    input  logic                               err_clr,
    output logic [2:0]                         cc,
    output logic                               ben,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               stack_err
);

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    function automatic logic [2:0] nzp_decode(input logic [DATA_W-1:0] val);
        logic [2:0] res;
        if (val == {DATA_W{1'b0}}) begin
            res = 3'b010;
        end else if (val[DATA_W-1]) begin
            res = 3'b100;
        end else begin
            res = 3'b001;
        end
        return res;
    endfunction

    logic [2:0]       cc_q, cc_d;
    logic             ben_q, ben_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic [2:0]       stack_q [STACK_DEPTH];

    logic             full_s, empty_s;
    logic             push_ok_s, pop_ok_s, err_ev_s;
    logic [CNT_W-1:0] top_cnt_s;
    logic [IDX_W-1:0] top_idx_s, wr_idx_s;
    logic [2:0]       top_val_s;

    assign full_s    = (count_q == CNT_W'(STACK_DEPTH));
    assign empty_s   = (count_q == {CNT_W{1'b0}});
    assign top_cnt_s = count_q - CNT_W'(1);
    assign top_idx_s = top_cnt_s[IDX_W-1:0];
    assign wr_idx_s  = count_q[IDX_W-1:0];
    assign top_val_s = stack_q[top_idx_s];

    // Simultaneous push and pop is treated as a conflict: neither happens.
    assign push_ok_s = cc_push & ~cc_pop & ~full_s;
    assign pop_ok_s  = cc_pop & ~cc_push & ~empty_s;
    assign err_ev_s  = (cc_push & cc_pop) | (cc_push & full_s) | (cc_pop & empty_s);

    // Next-state for CC, BEN, stack occupancy and the sticky error flag.
    always_comb begin
        cc_d    = cc_q;
        ben_d   = ben_q;
        count_d = count_q;
        err_d   = err_q;

        if (pop_ok_s) begin
            cc_d = top_val_s;
        end else if (ld_cc) begin
            cc_d = nzp_decode(dr_value);
        end else begin
            cc_d = cc_q;
        end

        if (push_ok_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok_s) begin
            count_d = top_cnt_s;
        end else begin
            count_d = count_q;
        end

        // A fresh error beats a clear in the same cycle.
        if (err_ev_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        // BEN always sees the pre-edge CC, even when CC changes this cycle.
        if (ld_ben) begin
            ben_d = |(ir_nzp & cc_q);
        end else begin
            ben_d = ben_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cc_q    <= CC_RST;
            ben_q   <= 1'b0;
            count_q <= {CNT_W{1'b0}};
            err_q   <= 1'b0;
        end else begin
            cc_q    <= cc_d;
            ben_q   <= ben_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Saved-CC storage; the pre-edge CC is captured on a successful push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= 3'b000;
            end
        end else if (push_ok_s) begin
            stack_q[wr_idx_s] <= cc_q;
        end
    end

    assign cc          = cc_q;
    assign ben         = ben_q;
    assign stack_count = count_q;
    assign stack_full  = full_s;
    assign stack_empty = empty_s;
    assign stack_err   = err_q;

endmodule

// File: tb/tb_cc_unit.sv
// Self-checking bench for cc_unit: a table of per-cycle vectors fed through a
// scoreboard queue, plus hand-written reset corner sequences.
module tb_cc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] dr_value;
    logic        ld_cc, cc_push, cc_pop, ld_ben, err_clr;
    logic [2:0]  ir_nzp;
    logic [2:0]  cc;
    logic        ben;
    logic [2:0]  stack_count;
    logic        stack_full, stack_empty, stack_err;

    int checks = 0;
    int errors = 0;

    cc_unit #(.DATA_W(16), .STACK_DEPTH(4), .CC_RST(3'b010)) dut (
        .clk(clk), .reset(reset), .dr_value(dr_value), .ld_cc(ld_cc),
        .cc_push(cc_push), .cc_pop(cc_pop), .ir_nzp(ir_nzp), .ld_ben(ld_ben),
        .err_clr(err_clr), .cc(cc), .ben(ben), .stack_count(stack_count),
        .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dr;
        logic        ld, psh, pp;
        logic [2:0]  nzp;
        logic        lb, ec;
        logic [2:0]  ecc;
        logic        eben;
        logic [2:0]  ecnt;
        logic        eerr;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(logic [15:0] dr, logic ld, logic psh, logic pp,
                                logic [2:0] nzp, logic lb, logic ec,
                                logic [2:0] ecc, logic eben, logic [2:0] ecnt, logic eerr);
        vec_t v;
        v.dr = dr; v.ld = ld; v.psh = psh; v.pp = pp; v.nzp = nzp; v.lb = lb; v.ec = ec;
        v.ecc = ecc; v.eben = eben; v.ecnt = ecnt; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        dr_value = 16'h0000; ld_cc = 1'b0; cc_push = 1'b0; cc_pop = 1'b0;
        ir_nzp = 3'b000; ld_ben = 1'b0; err_clr = 1'b0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        dr_value = v.dr; ld_cc = v.ld; cc_push = v.psh; cc_pop = v.pp;
        ir_nzp = v.nzp; ld_ben = v.lb; err_clr = v.ec;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("row%0d cc", idx), {13'd0, cc}, {13'd0, e.ecc});
        chk($sformatf("row%0d ben", idx), {15'd0, ben}, {15'd0, e.eben});
        chk($sformatf("row%0d count", idx), {13'd0, stack_count}, {13'd0, e.ecnt});
        chk($sformatf("row%0d err", idx), {15'd0, stack_err}, {15'd0, e.eerr});
        chk($sformatf("row%0d full", idx), {15'd0, stack_full}, {15'd0, (e.ecnt == 3'd4)});
        chk($sformatf("row%0d empty", idx), {15'd0, stack_empty}, {15'd0, (e.ecnt == 3'd0)});
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        #2;
        chk("rst cc", {13'd0, cc}, 16'h0002);
        chk("rst ben", {15'd0, ben}, 16'h0000);
        chk("rst count", {13'd0, stack_count}, 16'h0000);
        chk("rst empty", {15'd0, stack_empty}, 16'h0001);
        chk("rst err", {15'd0, stack_err}, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        //               dr        ld    psh   pp    nzp     lb    ec    ecc     ben   cnt   err
        tbl.push_back(mk(16'h0000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b010, 1'b0, 3'd0, 1'b0));
        tbl.push_back(mk(16'h8000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b100, 1'b0, 3'd0, 1'b0));
        tbl.push_back(mk(16'h7FFF, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b001, 1'b0, 3'd0, 1'b0));
        tbl.push_back(mk(16'hFFFF, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b100, 1'b0, 3'd0, 1'b0));
        tbl.push_back(mk(16'h0001, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b001, 1'b0, 3'd0, 1'b0));
        tbl.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b0, 3'b011, 1'b1, 1'b0, 3'b001, 1'b1, 3'd0, 1'b0));
        tbl.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0, 3'b001, 1'b0, 3'd0, 1'b0));
        tbl.push_back(mk(16'h8000, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0, 3'b100, 1'b0, 3'd0, 1'b0));
        tbl.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0, 3'b100, 1'b1, 3'd0, 1'b0));
        tbl.push_back(mk(16'h0000, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b100, 1'b1, 3'd1, 1'b0));
        tbl.push_back(mk(16'h0001, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 3'd1, 1'b0));
        tbl.push_back(mk(16'h0000, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 3'd2, 1'b0));
        tbl.push_back(mk(16'h0000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b010, 1'b1, 3'd2, 1'b0));
        tbl.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 3'd1, 1'b0));
        tbl.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b100, 1'b1, 3'd0, 1'b0));
        tbl.push_back(mk(16'h0000, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b010, 1'b1, 3'd1, 1'b0));
        tbl.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b100, 1'b1, 3'd0, 1'b0));
        tbl.push_back(mk(16'h7FFF, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 3'd1, 1'b0));
        tbl.push_back(mk(16'h0000, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b010, 1'b1, 3'd2, 1'b0));
        tbl.push_back(mk(16'h8000, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b100, 1'b1, 3'd3, 1'b0));
        tbl.push_back(mk(16'h0000, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b100, 1'b1, 3'd4, 1'b0));
        tbl.push_back(mk(16'h0001, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 3'd4, 1'b1));
        tbl.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 3'b001, 1'b1, 3'd4, 1'b0));
        tbl.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b100, 1'b1, 3'd3, 1'b0));
        tbl.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b010, 1'b1, 3'd2, 1'b0));
        tbl.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 3'd1, 1'b0));
        tbl.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b100, 1'b1, 3'd0, 1'b0));
        tbl.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b100, 1'b1, 3'd0, 1'b1));
        tbl.push_back(mk(16'h0000, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b010, 1'b1, 3'd0, 1'b1));
        tbl.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 3'b010, 1'b1, 3'd0, 1'b1));
        tbl.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 3'b010, 1'b1, 3'd0, 1'b0));
        tbl.push_back(mk(16'h0000, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b010, 1'b1, 3'd1, 1'b0));
        tbl.push_back(mk(16'h0000, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 3'b010, 1'b1, 3'd1, 1'b1));
        tbl.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 3'b010, 1'b1, 3'd1, 1'b0));
        tbl.push_back(mk(16'h8000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b100, 1'b1, 3'd1, 1'b0));
        tbl.push_back(mk(16'h0000, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b100, 1'b1, 3'd2, 1'b0));
        tbl.push_back(mk(16'h0000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b010, 1'b1, 3'd2, 1'b0));
        tbl.push_back(mk(16'h0001, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b100, 1'b1, 3'd1, 1'b0));
        tbl.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 3'b010, 1'b0, 3'd0, 1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i + 1);
        end

        // Reset pulse in the middle of a sequence with one entry saved.
        @(negedge clk);
        idle_inputs();
        cc_push = 1'b1;
        @(negedge clk);
        idle_inputs();
        ld_cc = 1'b1; dr_value = 16'h8000; ld_ben = 1'b1; ir_nzp = 3'b010;
        @(posedge clk);
        #1;
        chk("pre-rst cc", {13'd0, cc}, 16'h0004);
        chk("pre-rst count", {13'd0, stack_count}, 16'h0001);
        chk("pre-rst ben", {15'd0, ben}, 16'h0001);
        #2;
        reset = 1'b1;
        #1;
        chk("mid-rst cc", {13'd0, cc}, 16'h0002);
        chk("mid-rst count", {13'd0, stack_count}, 16'h0000);
        chk("mid-rst ben", {15'd0, ben}, 16'h0000);
        chk("mid-rst empty", {15'd0, stack_empty}, 16'h0001);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        cc_pop = 1'b1;
        @(posedge clk);
        #1;
        chk("post-rst pop err", {15'd0, stack_err}, 16'h0001);
        chk("post-rst pop cc", {13'd0, cc}, 16'h0002);
        chk("post-rst pop count", {13'd0, stack_count}, 16'h0000);
        @(negedge clk);
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
